// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants for the 5-position 7-segment scan display:
//             active-low glyphs {g,f,e,d,c,b,a} and position-index types.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int NUM_POS = 5;            // sign + 4 digits
    localparam int IDX_W   = 3;

    typedef logic [IDX_W-1:0] pos_idx_t;

    localparam pos_idx_t POS_UNITS = 3'd0;
    localparam pos_idx_t POS_SIGN  = 3'd4;  // also the last position in the scan

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_if
//  Purpose  : Value/control inputs and display drive outputs of the scanner.
//             master = value producer / board side, slave = seg7_scan.
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_if;
    import seg7_pkg::*;

    logic [15:0]        dec;    // packed BCD, [15:12] thousands .. [3:0] units
    logic               neg;    // 1 = negative
    logic               load;   // single-cycle capture strobe
    logic               lz_en;  // leading-zero blanking enable (live)
    logic [NUM_POS-1:0] an;     // anodes, active-low, an[4] = sign
    logic [6:0]         seg;    // segments {g,f,e,d,c,b,a}, active-low
    logic               dp;     // decimal point, active-low

    modport master (output dec, neg, load, lz_en, input  an, seg, dp);
    modport slave  (input  dec, neg, load, lz_en, output an, seg, dp);

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational BCD nibble to active-low 7-segment glyph lookup.
//             Nibbles above 9 show 'E' and ignore the blank request, so a
//             corrupt digit is never hidden.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  wire logic [3:0] i_digit,
    input  wire logic       i_blank,
    output logic      [6:0] o_seg
);

    // Glyph lookup; invalid digits override blanking
    always_comb begin
        o_seg = SEG_E;
        case (i_digit)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
        if (i_blank && (i_digit <= 4'd9)) begin
            o_seg = SEG_BLANK;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan
//  Purpose  : Time-multiplexed driver for a 5-position common-anode display
//             (sign + 4 BCD digits) with leading-zero blanking, invalid-digit
//             indication and an all-anodes-off gap at every position change.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV   = 50000,   // clk cycles per position, 2..2^20
    parameter int BLANK_CYC = 1        // anode-off cycles per position, < CLK_DIV
) (
    input  wire logic clk,
    input  wire logic rst_n,
    seg7_if.slave     disp
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_BLANK    = DIV_W'(BLANK_CYC);

    logic [15:0]        r_sh_dec;
    logic               r_sh_neg;
    logic [DIV_W-1:0]   r_div;
    pos_idx_t           r_idx;
    logic [6:0]         r_glyph;   // glyph for the position currently dwelling
    logic [NUM_POS-1:0] r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    pos_idx_t           w_idx_nxt;
    logic [3:0]         w_digit;
    logic               w_lz_zero;
    logic [6:0]         w_dec_seg;
    logic [6:0]         w_glyph;

    assign w_idx_nxt = (r_idx == POS_SIGN) ? POS_UNITS : r_idx + 3'd1;

    // Select the digit entering next and whether it and all higher digits are zero
    always_comb begin
        w_digit   = 4'h0;
        w_lz_zero = 1'b0;
        case (w_idx_nxt)
            3'd0: w_digit = r_sh_dec[3:0];
            3'd1: begin
                w_digit   = r_sh_dec[7:4];
                w_lz_zero = (r_sh_dec[15:4] == 12'h000);
            end
            3'd2: begin
                w_digit   = r_sh_dec[11:8];
                w_lz_zero = (r_sh_dec[15:8] == 8'h00);
            end
            3'd3: begin
                w_digit   = r_sh_dec[15:12];
                w_lz_zero = (r_sh_dec[15:12] == 4'h0);
            end
            default: begin
                w_digit   = 4'h0;
                w_lz_zero = 1'b0;
            end
        endcase
    end

    seg7_decode u_decode (
        .i_digit (w_digit),
        .i_blank (disp.lz_en && w_lz_zero),
        .o_seg   (w_dec_seg)
    );

    // Sign position: minus only for a nonzero magnitude, so -0 reads as 0
    assign w_glyph = (w_idx_nxt == POS_SIGN)
                   ? ((r_sh_neg && (r_sh_dec != 16'h0000)) ? SEG_MINUS : SEG_BLANK)
                   : w_dec_seg;

    // Shadow register for the displayed value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dec <= 16'h0000;
            r_sh_neg <= 1'b0;
        end else if (disp.load) begin
            r_sh_dec <= disp.dec;
            r_sh_neg <= disp.neg;
        end
    end

    // Dwell divider and position index; the next glyph is latched from the
    // pre-load shadow on the advance edge so a coincident load waits a position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= POS_UNITS;
            r_glyph <= SEG_0;
        end else if (r_div == c_DIV_LAST) begin
            r_div   <= '0;
            r_idx   <= w_idx_nxt;
            r_glyph <= w_glyph;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    // Output drive: segments only move while anodes are forced off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_dp <= 1'b1;
            if (r_div < c_BLANK) begin
                r_an  <= '1;
                r_seg <= r_glyph;
            end else begin
                r_an  <= ~(NUM_POS'(1) << r_idx);
            end
        end
    end

    assign disp.an  = r_an;
    assign disp.seg = r_seg;
    assign disp.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan
//  Purpose  : Self-checking bench for seg7_scan (CLK_DIV=4, BLANK_CYC=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    localparam int CD = 4;
    localparam int BL = 1;

    typedef struct {
        logic [15:0] dec;
        logic        neg;
        logic        lz;
        logic [6:0]  exp [5];   // units, tens, hundreds, thousands, sign
    } vec_t;

    logic clk;
    logic rst_n;
    seg7_if u_if ();

    seg7_scan #(.CLK_DIV(CD), .BLANK_CYC(BL)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: time since reset release, shadow value, glyph per visit
    int          n;
    int          cur_ph;
    int          cur_pos;
    logic [15:0] m_dec;
    logic        m_neg;
    logic [6:0]  m_pend;
    logic [6:0]  e_seg;
    logic [4:0]  e_an;
    logic [6:0]  glyph_tbl [10];

    function automatic logic [6:0] ref_glyph(int pos, logic [15:0] d, logic ng, logic lz);
        logic [15:0] upper;
        int nib;
        if (pos == 4) return (ng && d != 0) ? 7'h3F : 7'h7F;
        upper = d >> (4 * pos);
        nib   = int'(upper & 16'hF);
        if (nib > 9) return 7'h06;
        if (lz && pos > 0 && upper == 0) return 7'h7F;
        return glyph_tbl[nib];
    endfunction

    task automatic model_reset();
        n = 0; cur_ph = 0; cur_pos = 0;
        m_dec = 16'h0; m_neg = 1'b0;
        m_pend = 7'h40;
        e_an = 5'h1F; e_seg = 7'h7F;
    endtask

    task automatic model_edge(input logic l, input logic [15:0] d, input logic ng, input logic lz);
        n++;
        cur_ph  = (n - 1) % CD;
        cur_pos = ((n - 1) / CD) % 5;
        if (cur_ph == CD - 1) m_pend = ref_glyph((cur_pos + 1) % 5, m_dec, m_neg, lz);
        if (l) begin m_dec = d; m_neg = ng; end
        if (cur_ph < BL) begin
            e_an  = 5'h1F;
            e_seg = m_pend;
        end else begin
            e_an = ~(5'b00001 << cur_pos);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (edge %0d, t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    // One clock: sample inputs as the DUT sees them, advance model, compare
    task automatic tick();
        logic l, ng, lz;
        logic [15:0] d;
        l = u_if.load; d = u_if.dec; ng = u_if.neg; lz = u_if.lz_en;
        @(posedge clk);
        #1;
        model_edge(l, d, ng, lz);
        chk("an",  16'(u_if.an),  16'(e_an));
        chk("seg", 16'(u_if.seg), 16'(e_seg));
        chk("dp",  16'(u_if.dp),  16'h1);
    endtask

    task automatic wait_at(input int pos, input int ph, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cur_pos == pos && cur_ph == ph && n > 0) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_pos%0d_ph%0d: timed out", pos, ph);
        end
    endtask

    task automatic load_val(input logic [15:0] d, input logic ng);
        u_if.dec = d; u_if.neg = ng; u_if.load = 1'b1;
        tick();
        u_if.load = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        bit ok;
        glyph_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vecs[0] = '{16'h1234, 1'b0, 1'b1, '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F}};
        vecs[1] = '{16'h0007, 1'b1, 1'b1, '{7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h3F}};
        vecs[2] = '{16'h0007, 1'b1, 1'b0, '{7'h78, 7'h40, 7'h40, 7'h40, 7'h3F}};
        vecs[3] = '{16'h0000, 1'b1, 1'b1, '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[4] = '{16'h0A05, 1'b0, 1'b1, '{7'h12, 7'h40, 7'h06, 7'h7F, 7'h7F}};
        vecs[5] = '{16'h0A05, 1'b1, 1'b0, '{7'h12, 7'h40, 7'h06, 7'h40, 7'h3F}};
        vecs[6] = '{16'h9876, 1'b0, 1'b0, '{7'h02, 7'h78, 7'h00, 7'h10, 7'h7F}};
        vecs[7] = '{16'hF00B, 1'b1, 1'b1, '{7'h06, 7'h40, 7'h40, 7'h06, 7'h3F}};

        rst_n = 1'b0;
        u_if.dec = 16'h0; u_if.neg = 1'b0; u_if.load = 1'b0; u_if.lz_en = 1'b1;
        model_reset();

        // Reset held: outputs quiescent
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_an",  16'(u_if.an),  16'h1F);
            chk("rst_seg", 16'(u_if.seg), 16'h7F);
            chk("rst_dp",  16'(u_if.dp),  16'h1);
        end
        rst_n = 1'b1;
        tick();
        chk("rel1_an", 16'(u_if.an), 16'h1F);
        tick();
        chk("rel2_an",  16'(u_if.an),  16'h1E);
        chk("rel2_seg", 16'(u_if.seg), 16'h40);

        // Table-driven full scans
        for (int v = 0; v < 8; v++) begin
            u_if.lz_en = vecs[v].lz;
            load_val(vecs[v].dec, vecs[v].neg);
            repeat (6 * CD) tick();
            for (int c = 0; c < 5 * CD; c++) begin
                tick();
                if (cur_ph == BL) chk($sformatf("tbl%0d_pos%0d", v, cur_pos),
                                      16'(u_if.seg), 16'(vecs[v].exp[cur_pos]));
            end
        end

        // Load coinciding with the advance edge into tens
        u_if.lz_en = 1'b1;
        load_val(16'h1234, 1'b0);
        repeat (6 * CD) tick();
        wait_at(0, CD - 2, ok);
        load_val(16'h5678, 1'b0);
        wait_at(1, BL, ok);
        if (ok) chk("adv_old_tens", 16'(u_if.seg), 16'h30);
        wait_at(2, BL, ok);
        if (ok) chk("adv_new_hund", 16'(u_if.seg), 16'h02);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            u_if.load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1)
                u_if.dec = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else if ($urandom_range(0, 2) == 0)
                u_if.dec = 16'($urandom_range(0, 15));
            else
                u_if.dec = 16'($urandom);
            u_if.neg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) u_if.lz_en = ~u_if.lz_en;
            tick();
        end
        u_if.load = 1'b0;

        // Asynchronous reset mid-dwell at thousands
        u_if.lz_en = 1'b1;
        load_val(16'h4321, 1'b1);
        repeat (6 * CD) tick();
        wait_at(3, 2, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an",  16'(u_if.an),  16'h1F);
        chk("async_seg", 16'(u_if.seg), 16'h7F);
        @(posedge clk); #1;
        chk("async_hold_an", 16'(u_if.an), 16'h1F);
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("restart_blank", 16'(u_if.an), 16'h1F);
        tick();
        chk("restart_an0",  16'(u_if.an),  16'h1E);
        chk("restart_seg0", 16'(u_if.seg), 16'h40);
        wait_at(1, BL, ok);
        if (ok) chk("restart_tens_blank", 16'(u_if.seg), 16'h7F);
        wait_at(4, BL, ok);
        if (ok) chk("restart_sign_blank", 16'(u_if.seg), 16'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Display stage directly downstream of the binary-to-BCD converter.
- Captures the converter's 16-bit packed BCD result (4 digits) plus a sign flag.
- Time-multiplexes the value onto a 5-position common-anode 7-segment display: sign position plus 4 digits.
- Provides leading-zero blanking, an invalid-digit indicator and anti-ghosting blanking between positions.

Parameters:
- CLK_DIV, 50000: clk cycles per display position (dwell time); legal range 2..2^20.
- BLANK_CYC, 1: clk cycles with all anodes off at each position change; must be < CLK_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dec  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- neg  in  1  sign of the displayed value (1 = negative).
- load  in  1  single-cycle strobe; captures dec/neg into the shadow register.
- lz_en  in  1  leading-zero blanking enable (sampled live, not shadowed).
- an  out  5  anode selects, active-low; an[0]=units … an[3]=thousands, an[4]=sign.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - On rst_n=0: shadow value 0, shadow sign 0, div counter 0, position index 0, an=5'b11111, seg=7'h7F, dp=1.
- Shadow capture:
  - On the posedge with load=1: shadow_dec<=dec, shadow_neg<=neg.
  - With load=0 the shadow holds its value.
  - The new value appears at the next position visit; the current position is not re-rendered mid-dwell.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - When div==CLK_DIV-1: idx advances 0→1→2→3→4→0, and the decode register captures the glyph for the new idx.
- Anti-ghosting:
  - While div < BLANK_CYC, an=5'b11111.
  - Otherwise an drives a one-hot-low select for idx.
  - seg changes only when an is all-off.
- Glyph decode:
  - BCD 0–9 maps to standard glyphs; 0 = 7'h40 active-low.
  - Nibble > 9 maps to 'E' (7'h06) and is never blanked.
- Leading-zero blanking (lz_en=1):
  - Digit k in 1..3 shows blank (7'h7F) if it and all higher digits are 0.
  - Units (k=0) is never blanked.
- Sign position (idx=4):
  - Shows '-' (7'h3F) iff shadow_neg=1 and shadow_dec≠0; otherwise blank.
  - -0 displays as 0.
- Output registering: all outputs are registered; there is no combinational path from inputs to outputs.
- Simultaneous events: load on the same edge as an idx advance: decode uses the old shadow for that position; the new value is used from the following position on.
- Reset mid-scan: returns to idx 0 with the blank interval first; the shadow is cleared (display shows "0", units only, if lz_en=1).
- Full-cycle period: 5*CLK_DIV clk cycles.

Decomposition:
- Shared package seg7_pkg:
  - Active-low glyph constants SEG_0..SEG_9, SEG_E, SEG_MINUS, SEG_BLANK.
  - Position-index width and NUM_POS=5.
- Sub-module seg7_decode:
  - Purely combinational nibble→glyph lookup.
  - Inputs: 4-bit digit, blank flag. Output: 7-bit seg.
  - Instantiated once inside seg7_scan.
- Leading-zero logic and scan counters stay in seg7_scan.

Test Plan (CLK_DIV=4, BLANK_CYC=1):
- Reset: hold rst_n=0 for 3 cycles.
  - Required: an=11111, seg=7F, dp=1 throughout.
  - After release, an[0] goes low on cycle 2 and seg=40.
- Load dec=16'h1234, neg=0, lz_en=1; scan 20 cycles.
  - Required: positions 0..3 show 4,3,2,1 (seg 19,30,24,79).
  - Sign position is blank (7F).
  - Each position has one cycle with an=11111.
- Load dec=16'h0007, neg=1, lz_en=1.
  - Required: units 78; tens, hundreds and thousands 7F; sign 3F.
  - With lz_en=0, the upper three positions show 40.
- Load dec=16'h0000, neg=1.
  - Required: sign blank, units 40 (no -0).
- Load dec=16'h0A05.
  - Required: hundreds shows 06 ('E').
  - Thousands is blanked with lz_en=1; tens shows 40 (not leading once a nonzero higher digit exists).
- Assert load on the idx-advance edge with a new value.
  - Required: the entering position uses the old digit; subsequent positions use the new digits.
- Assert rst_n=0 mid-dwell at idx 3.
  - Required: an=11111 immediately (asynchronous), and the scan restarts at idx 0.
